bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-requester arbiter and sequencer for the shared external memory/IO bus. It sits between the CPU core (requester 0) and a second bus master such as DMA or video fetch (requester 1), and the external bus signals, with the CPU's bus port wired to requester 0. Fair round-robin arbitration selects one requester at a time. The block registers that requester's transaction, drives the bus until the ready handshake completes, and returns read data with a one-cycle acknowledge.

## Interface
- ADDR_W, 32, address width (matches CPU wide address bus)
- DATA_W, 32, data width (matches CPU wide data bus)
- TIMEOUT_CYCLES, 255, bus-ready watchdog limit; used only with BUS_ARB_TIMEOUT_EN
- i_cpu_clk  in  1  single clock, all logic on rising edge
- i_rst  in  1  asynchronous, active-low reset
- i_req[1:0]  in  2  per-requester request level
- i_we[1:0]  in  2  per-requester write enable (1 = write)
- i_addr0, i_addr1  in  ADDR_W  per-requester address
- i_wdata0, i_wdata1  in  DATA_W  per-requester write data
- o_ack[1:0]  out  2  one-cycle completion pulse, one-hot
- o_err[1:0]  out  2  timeout flag, valid with o_ack
- o_rdata  out  DATA_W  read data, valid while any o_ack bit is high
- o_gnt[1:0]  out  2  current owner, one-hot, high from issue through ack
- o_bus_cyc  out  1  bus transaction active
- o_bus_we, o_bus_addr, o_bus_data  out  1/ADDR_W/DATA_W  registered transaction fields
- i_bus_data  in  DATA_W  bus read data
- i_bus_data_ready  in  1  bus completion

## Operation
- States:
  - IDLE: if any i_req is high, pick a winner, latch its we/addr/wdata into the o_bus_* registers, set o_gnt, and go to BUSY.
  - BUSY: o_bus_cyc is high. When i_bus_data_ready is sampled high, latch i_bus_data into o_rdata (for writes, latch 0) and go to ACK.
  - ACK: drive o_ack for the owner, drop o_bus_cyc, and go to IDLE. In the following IDLE cycle, o_gnt clears.
- Winner selection:
  - If only one requester is asserting, that requester wins.
  - If both are asserting, the requester that is not `last_owner` wins.
  - `last_owner` updates on every grant and resets to 1, so the CPU wins the first tie.
- Requester rules:
  - Hold we/addr/wdata stable from req rise until ack.
  - Req still high in the cycle after ack counts as a new request.
- i_bus_data_ready is ignored outside BUSY.
- i_req changes during BUSY or ACK have no effect on the current transaction.
- Reset (asynchronous, at any state including mid-BUSY) drives every output to 0, returns the FSM to IDLE, and sets last_owner = 1. An in-flight transaction is abandoned without ack.

## Timing
- Req sampled high at edge E0. At E0 the state becomes BUSY and o_bus_* plus o_gnt are valid.
- Ready sampled high at edge En (n ≥ 1). At En o_ack and o_rdata are valid for exactly one cycle.
- At En+1 the state is IDLE. A new grant occurs no earlier than En+2.
- Minimum transaction is 3 cycles (ready already high at E1). With both requesters continuously asserting, grants alternate.
- Reset values: o_ack=0, o_err=0, o_rdata=0, o_gnt=0, o_bus_cyc=0, o_bus_we=0, o_bus_addr=0, o_bus_data=0.

## Configuration
- BUS_ARB_TIMEOUT_EN defined:
  - An 8..16-bit counter clears on entry to BUSY and increments each BUSY cycle.
  - When the counter reaches TIMEOUT_CYCLES without ready, the FSM goes to ACK with o_err[owner]=1 and o_rdata=0.
  - If ready and timeout coincide, ready wins (err=0).
- Undefined: there is no counter. BUSY waits indefinitely, and o_err is tied to 0.

## Structure
- Package bus_arb_pkg: state enum (IDLE, BUSY, ACK), requester index constants REQ_CPU=0 and REQ_AUX=1, default TIMEOUT_CYCLES.
- Sub-module bus_arb_rr: combinational round-robin pick (inputs req[1:0] and last_owner; outputs one-hot winner and a valid flag).
- Top level holds the FSM, transaction registers and watchdog.

## Test plan
- Single CPU read: req0 with addr 0x0000_1234, ready asserted 2 cycles after o_bus_cyc rises, i_bus_data=0xDEAD_BEEF -> o_ack=01, o_rdata=0xDEAD_BEEF, o_err=00, o_bus_we=0 throughout.
- Tie after reset: req=11 at the same edge -> requester 0 is granted first, then requester 1. Continuous req=11 for 4 transactions -> grant order 0,1,0,1.
- Write from aux: req1, we1=1, addr 0x0002_0000, wdata 0x0000_00A5 -> o_bus_addr/o_bus_data/o_bus_we match while o_bus_cyc=1. o_ack=10 with o_rdata=0.
- Ready glitches: ready pulsed in IDLE and in ACK -> no effect. A ready pulse in BUSY completes exactly one transaction.
- Reset mid-BUSY: i_rst low during BUSY -> all outputs 0 immediately. After release, a pending req0 is re-granted from IDLE with no stale ack.
- With BUS_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, ready never asserted -> ack with o_err[owner]=1 and o_rdata=0 after 4 BUSY cycles. With ready and timeout on the same cycle -> o_err=0.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared types and constants for the two-requester bus arbiter.
// The optional bus-ready watchdog in bus_arbiter is enabled by defining BUS_ARB_TIMEOUT_EN.
package bus_arb_pkg;

    // Transaction sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } arb_state_t;

    // Requester indices: CPU core on port 0, auxiliary master (DMA/video) on port 1
    localparam int REQ_CPU = 0;
    localparam int REQ_AUX = 1;

    // Default bus-ready watchdog limit and watchdog counter width
    localparam int TIMEOUT_CYCLES_DEF = 255;
    localparam int WDOG_W             = 16;

endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: requester-side and external-bus-side signals of the arbiter.
// The slave modport is the arbiter's view; master is the view of whatever drives
// the requests and the external bus (CPU/DMA/bus model).
interface bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Requester side
    logic [1:0]        i_req;
    logic [1:0]        i_we;
    logic [ADDR_W-1:0] i_addr0;
    logic [ADDR_W-1:0] i_addr1;
    logic [DATA_W-1:0] i_wdata0;
    logic [DATA_W-1:0] i_wdata1;
    logic [1:0]        o_ack;
    logic [1:0]        o_err;
    logic [DATA_W-1:0] o_rdata;
    logic [1:0]        o_gnt;

    // External bus side
    logic              o_bus_cyc;
    logic              o_bus_we;
    logic [ADDR_W-1:0] o_bus_addr;
    logic [DATA_W-1:0] o_bus_data;
    logic [DATA_W-1:0] i_bus_data;
    logic              i_bus_data_ready;

    modport slave (
        input  i_req, i_we, i_addr0, i_addr1, i_wdata0, i_wdata1,
        input  i_bus_data, i_bus_data_ready,
        output o_ack, o_err, o_rdata, o_gnt,
        output o_bus_cyc, o_bus_we, o_bus_addr, o_bus_data
    );

    modport master (
        output i_req, i_we, i_addr0, i_addr1, i_wdata0, i_wdata1,
        output i_bus_data, i_bus_data_ready,
        input  o_ack, o_err, o_rdata, o_gnt,
        input  o_bus_cyc, o_bus_we, o_bus_addr, o_bus_data
    );
endinterface

// File: rtl/bus_arb_rr.sv
// bus_arb_rr: combinational two-way round-robin pick.
// A lone requester always wins; on a tie the requester that did not own the bus
// last time wins.
module bus_arb_rr
    import bus_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic [1:0] winner,
    output logic       valid
);

    // Requester gi wins if it asks and either the other one is silent or gi was not last owner
    for (genvar gi = 0; gi < 2; gi++) begin : g_pick
        assign winner[gi] = req[gi] & (~req[1-gi] | (last_owner != 1'(gi)));
    end

    assign valid = |req;

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-requester round-robin arbiter and sequencer for the shared
// external memory/IO bus. Requester 0 is the CPU, requester 1 the auxiliary master.
// Optional feature macro: BUS_ARB_TIMEOUT_EN (bus-ready watchdog, TIMEOUT_CYCLES).
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic           i_cpu_clk,
    input  logic           i_rst,
    bus_arbiter_if.slave   bus
);

    arb_state_t        state_reg;
    logic              last_owner_reg;
    logic [1:0]        winner;
    logic              win_valid;
    logic              timeout_hit;
    logic              we_sel;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;

    bus_arb_rr u_rr (
        .req        (bus.i_req),
        .last_owner (last_owner_reg),
        .winner     (winner),
        .valid      (win_valid)
    );

    // Route the winning requester's transaction fields toward the bus registers
    always_comb begin
        we_sel    = bus.i_we[REQ_CPU];
        addr_sel  = bus.i_addr0;
        wdata_sel = bus.i_wdata0;
        if (winner[REQ_AUX]) begin
            we_sel    = bus.i_we[REQ_AUX];
            addr_sel  = bus.i_addr1;
            wdata_sel = bus.i_wdata1;
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);
    logic [WDOG_W-1:0] wdog_reg;

    // Watchdog: held at zero outside a transaction, counts every BUSY cycle
    always_ff @(posedge i_cpu_clk or negedge i_rst) begin
        if (!i_rst) begin
            wdog_reg <= '0;
        end else if (state_reg == IDLE) begin
            wdog_reg <= '0;
        end else if (state_reg == BUSY) begin
            wdog_reg <= wdog_reg + 1'b1;
        end
    end

    // Last permitted BUSY cycle; an edge that sees this without ready times out
    assign timeout_hit = (state_reg == BUSY) && (wdog_reg == WDOG_LAST);
`else
    assign timeout_hit = 1'b0;
    wire unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    // Sequencer FSM: issue on grant, wait for ready (or timeout), pulse ack, release
    always_ff @(posedge i_cpu_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_reg      <= IDLE;
            last_owner_reg <= 1'(REQ_AUX);
            bus.o_ack      <= '0;
            bus.o_err      <= '0;
            bus.o_rdata    <= '0;
            bus.o_gnt      <= '0;
            bus.o_bus_cyc  <= 1'b0;
            bus.o_bus_we   <= 1'b0;
            bus.o_bus_addr <= '0;
            bus.o_bus_data <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (win_valid) begin
                        bus.o_bus_we   <= we_sel;
                        bus.o_bus_addr <= addr_sel;
                        bus.o_bus_data <= wdata_sel;
                        bus.o_gnt      <= winner;
                        bus.o_bus_cyc  <= 1'b1;
                        last_owner_reg <= winner[REQ_AUX];
                        state_reg      <= BUSY;
                    end
                end
                BUSY: begin
                    // Ready takes priority over a coinciding timeout
                    if (bus.i_bus_data_ready) begin
                        bus.o_rdata   <= bus.o_bus_we ? '0 : bus.i_bus_data;
                        bus.o_ack     <= bus.o_gnt;
                        bus.o_bus_cyc <= 1'b0;
                        state_reg     <= ACK;
                    end else if (timeout_hit) begin
                        bus.o_rdata   <= '0;
                        bus.o_ack     <= bus.o_gnt;
                        bus.o_err     <= bus.o_gnt;
                        bus.o_bus_cyc <= 1'b0;
                        state_reg     <= ACK;
                    end
                end
                ACK: begin
                    bus.o_ack   <= '0;
                    bus.o_err   <= '0;
                    bus.o_rdata <= '0;
                    bus.o_gnt   <= '0;
                    state_reg   <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed-vector bench for bus_arbiter.
// Optional timeout checks run when BUS_ARB_TIMEOUT_EN is defined (TIMEOUT_CYCLES=4).
module tb_bus_arbiter;
    import bus_arb_pkg::*;

    logic clk;
    logic rst_n;
    int   vec_cnt;
    int   err_cnt;

    bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    bus_arbiter #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .i_cpu_clk (clk),
        .i_rst     (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop if something hangs despite the bounded waits
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Wait (bounded) for a fresh grant with the bus cycle active
    task automatic wait_gnt(output logic [1:0] g);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.o_bus_cyc && (bus.o_gnt != 2'b00)) break;
        end
        check("gnt_seen", {63'd0, bus.o_bus_cyc}, 64'd1);
        g = bus.o_gnt;
    endtask

    // Wait (bounded) for the ack pulse; n is the number of edges it took
    task automatic wait_ack(output logic [1:0] a, output logic [31:0] rd,
                            output logic [1:0] e, output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            if (bus.o_ack != 2'b00) break;
        end
        check("ack_seen", {63'd0, |bus.o_ack}, 64'd1);
        a  = bus.o_ack;
        rd = bus.o_rdata;
        e  = bus.o_err;
        $display("txn: ack=%b err=%b rdata=0x%08h after %0d cycles", a, e, rd, n);
    endtask

    logic [1:0]  g;
    logic [1:0]  a;
    logic [1:0]  e;
    logic [31:0] rd;
    int          n;
    int          ack_count;
    logic [1:0]  tie_exp [4];

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        tie_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
        rst_n                = 1'b0;
        bus.i_req            = 2'b00;
        bus.i_we             = 2'b00;
        bus.i_addr0          = '0;
        bus.i_addr1          = '0;
        bus.i_wdata0         = '0;
        bus.i_wdata1         = '0;
        bus.i_bus_data       = '0;
        bus.i_bus_data_ready = 1'b0;

        // Reset state
        #1;
        check("rst_ack",   {62'd0, bus.o_ack}, 64'd0);
        check("rst_err",   {62'd0, bus.o_err}, 64'd0);
        check("rst_rdata", {32'd0, bus.o_rdata}, 64'd0);
        check("rst_gnt",   {62'd0, bus.o_gnt}, 64'd0);
        check("rst_cyc",   {63'd0, bus.o_bus_cyc}, 64'd0);
        check("rst_we",    {63'd0, bus.o_bus_we}, 64'd0);
        check("rst_addr",  {32'd0, bus.o_bus_addr}, 64'd0);
        check("rst_data",  {32'd0, bus.o_bus_data}, 64'd0);
        tick();
        rst_n = 1'b1;

        // Single CPU read, ready sampled two edges after issue
        bus.i_req   = 2'b01;
        bus.i_we    = 2'b00;
        bus.i_addr0 = 32'h0000_1234;
        wait_gnt(g);
        check("rd_gnt",  {62'd0, g}, 64'h1);
        check("rd_addr", {32'd0, bus.o_bus_addr}, 64'h1234);
        check("rd_we0",  {63'd0, bus.o_bus_we}, 64'd0);
        bus.i_req = 2'b00;
        tick();
        check("rd_busy_cyc", {63'd0, bus.o_bus_cyc}, 64'd1);
        check("rd_busy_ack", {62'd0, bus.o_ack}, 64'd0);
        bus.i_bus_data_ready = 1'b1;
        bus.i_bus_data       = 32'hDEAD_BEEF;
        wait_ack(a, rd, e, n);
        bus.i_bus_data_ready = 1'b0;
        check("rd_ack",   {62'd0, a}, 64'h1);
        check("rd_rdata", {32'd0, rd}, 64'hDEAD_BEEF);
        check("rd_err",   {62'd0, e}, 64'h0);
        check("rd_lat",   n, 64'd1);
        check("rd_we1",   {63'd0, bus.o_bus_we}, 64'd0);
        check("rd_ackcyc", {63'd0, bus.o_bus_cyc}, 64'd0);
        tick();
        check("rd_ack_drop", {62'd0, bus.o_ack}, 64'd0);
        check("rd_gnt_drop", {62'd0, bus.o_gnt}, 64'd0);

        // Tie after reset: CPU first, then strict alternation
        do_reset();
        bus.i_req            = 2'b11;
        bus.i_bus_data_ready = 1'b1;
        bus.i_bus_data       = 32'h0000_0011;
        for (int t = 0; t < 4; t++) begin
            wait_gnt(g);
            check("tie_gnt", {62'd0, g}, {62'd0, tie_exp[t]});
            wait_ack(a, rd, e, n);
            check("tie_ack", {62'd0, a}, {62'd0, tie_exp[t]});
        end
        bus.i_req            = 2'b00;
        bus.i_bus_data_ready = 1'b0;
        tick();
        tick();

        // Write from aux
        bus.i_req    = 2'b10;
        bus.i_we     = 2'b10;
        bus.i_addr1  = 32'h0002_0000;
        bus.i_wdata1 = 32'h0000_00A5;
        wait_gnt(g);
        check("wr_gnt",  {62'd0, g}, 64'h2);
        check("wr_addr", {32'd0, bus.o_bus_addr}, 64'h0002_0000);
        check("wr_data", {32'd0, bus.o_bus_data}, 64'hA5);
        check("wr_we",   {63'd0, bus.o_bus_we}, 64'd1);
        bus.i_req = 2'b00;
        tick();
        check("wr_hold_addr", {32'd0, bus.o_bus_addr}, 64'h0002_0000);
        check("wr_hold_we",   {63'd0, bus.o_bus_we}, 64'd1);
        bus.i_bus_data_ready = 1'b1;
        bus.i_bus_data       = 32'h1234_5678;
        wait_ack(a, rd, e, n);
        bus.i_bus_data_ready = 1'b0;
        bus.i_we             = 2'b00;
        check("wr_ack",   {62'd0, a}, 64'h2);
        check("wr_rdata", {32'd0, rd}, 64'h0);
        tick();

        // Ready glitches in IDLE and ACK; one BUSY pulse gives exactly one ack
        bus.i_bus_data_ready = 1'b1;
        tick();
        check("glitch_idle_ack", {62'd0, bus.o_ack}, 64'd0);
        check("glitch_idle_cyc", {63'd0, bus.o_bus_cyc}, 64'd0);
        bus.i_bus_data_ready = 1'b0;
        bus.i_req   = 2'b01;
        bus.i_addr0 = 32'h0000_0040;
        wait_gnt(g);
        bus.i_req = 2'b00;
        tick();
        bus.i_bus_data_ready = 1'b1;
        bus.i_bus_data       = 32'h0000_0055;
        wait_ack(a, rd, e, n);
        check("glitch_ack",   {62'd0, a}, 64'h1);
        check("glitch_rdata", {32'd0, rd}, 64'h55);
        ack_count = 0;
        tick();
        if (bus.o_ack != 2'b00) ack_count++;
        bus.i_bus_data_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (bus.o_ack != 2'b00 || bus.o_bus_cyc) ack_count++;
        end
        check("glitch_extra_acks", ack_count, 64'd0);

        // Reset in the middle of BUSY
        bus.i_req   = 2'b01;
        bus.i_addr0 = 32'h0000_0080;
        wait_gnt(g);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_outs", {bus.o_ack, bus.o_err, bus.o_gnt, bus.o_bus_cyc, bus.o_bus_we, 57'd0}, 64'd0);
        check("mid_rst_addr", {32'd0, bus.o_bus_addr}, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        wait_gnt(g);
        check("mid_rst_regnt", {62'd0, g}, 64'h1);
        check("mid_rst_noack", {62'd0, bus.o_ack}, 64'd0);
        check("mid_rst_addr2", {32'd0, bus.o_bus_addr}, 64'h80);
        bus.i_req            = 2'b00;
        bus.i_bus_data_ready = 1'b1;
        bus.i_bus_data       = 32'h0000_0099;
        wait_ack(a, rd, e, n);
        bus.i_bus_data_ready = 1'b0;
        check("mid_rst_ack", {62'd0, a}, 64'h1);
        tick();

`ifdef BUS_ARB_TIMEOUT_EN
        // Ready never arrives: timeout after 4 BUSY cycles
        bus.i_req   = 2'b01;
        bus.i_addr0 = 32'h0000_0100;
        wait_gnt(g);
        bus.i_req = 2'b00;
        wait_ack(a, rd, e, n);
        check("to_ack",   {62'd0, a}, 64'h1);
        check("to_err",   {62'd0, e}, 64'h1);
        check("to_rdata", {32'd0, rd}, 64'h0);
        check("to_lat",   n, 64'd4);
        tick();
        // Ready on the timeout edge wins
        bus.i_req   = 2'b10;
        bus.i_addr1 = 32'h0000_0200;
        wait_gnt(g);
        bus.i_req = 2'b00;
        tick();
        tick();
        tick();
        check("to_race_pending", {62'd0, bus.o_ack}, 64'd0);
        bus.i_bus_data_ready = 1'b1;
        bus.i_bus_data       = 32'h0000_0077;
        tick();
        bus.i_bus_data_ready = 1'b0;
        check("to_race_ack",   {62'd0, bus.o_ack}, 64'h2);
        check("to_race_err",   {62'd0, bus.o_err}, 64'h0);
        check("to_race_rdata", {32'd0, bus.o_rdata}, 64'h77);
        tick();
`else
        // No watchdog: BUSY waits with no ack and no error
        bus.i_req   = 2'b01;
        bus.i_addr0 = 32'h0000_0100;
        wait_gnt(g);
        bus.i_req = 2'b00;
        ack_count = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.o_ack != 2'b00 || bus.o_err != 2'b00) ack_count++;
        end
        check("nowdog_acks", ack_count, 64'd0);
        check("nowdog_cyc",  {63'd0, bus.o_bus_cyc}, 64'd1);
        bus.i_bus_data_ready = 1'b1;
        bus.i_bus_data       = 32'h0000_0066;
        wait_ack(a, rd, e, n);
        bus.i_bus_data_ready = 1'b0;
        check("nowdog_ack", {62'd0, a}, 64'h1);
        check("nowdog_err", {62'd0, e}, 64'h0);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
